// File: rtl/uart_rx_deframe.sv
// UART receive deframer: 16x oversampled start detection, mid-bit sampling of
// start, 8 data bits (LSB first), optional parity and stop, with held frame fields.
module uart_rx_deframe #(
  parameter int OVERSAMPLE = 16,
  parameter int MID_SAMPLE = OVERSAMPLE / 2 - 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       baud_tick16,
  input  logic       rx_serial,
  input  logic [1:0] parity_type,
  output logic [7:0] raw_data,
  output logic       parity_bit,
  output logic       start_bit,
  output logic       stop_bit,
  output logic       recieved_flag,
  output logic       rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_T  = TW'(MID_SAMPLE);
  localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, rx_s_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_en_q, par_en_d;
  logic [7:0]    shift_q, shift_d;
  logic          start_smp_q, start_smp_d;
  logic          par_smp_q, par_smp_d;
  logic [7:0]    raw_data_q, raw_data_d;
  logic          parity_bit_q, parity_bit_d;
  logic          start_bit_q, start_bit_d;
  logic          stop_bit_q, stop_bit_d;
  logic          flag_q, flag_d;
  logic          busy_q, busy_d;
  logic          at_mid, at_last;

  assign at_mid  = (tick_cnt_q == MID_T);
  assign at_last = (tick_cnt_q == LAST_T);

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    par_en_d     = par_en_q;
    shift_d      = shift_q;
    start_smp_d  = start_smp_q;
    par_smp_d    = par_smp_q;
    raw_data_d   = raw_data_q;
    parity_bit_d = parity_bit_q;
    start_bit_d  = start_bit_q;
    stop_bit_d   = stop_bit_q;
    flag_d       = flag_q;
    busy_d       = busy_q;

    if (baud_tick16) begin
      tick_cnt_d = at_last ? '0 : tick_cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          tick_cnt_d = '0;
          if (!rx_s_q) begin
            state_d  = START;
            par_en_d = ^parity_type;
            flag_d   = 1'b0;
            busy_d   = 1'b1;
          end
        end
        START: begin
          if (at_mid) start_smp_d = rx_s_q;
          if (at_last) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          if (at_mid) shift_d = {rx_s_q, shift_q[7:1]};
          if (at_last) begin
            if (bit_cnt_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
            else                   bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
          if (at_mid)  par_smp_d = rx_s_q;
          if (at_last) state_d   = STOP;
        end
        STOP: begin
          // Published fields change only here, so they stay stable through the next frame.
          if (at_mid) begin
            stop_bit_d   = rx_s_q;
            raw_data_d   = shift_q;
            start_bit_d  = start_smp_q;
            parity_bit_d = par_en_q ? par_smp_q : 1'b1;
            flag_d       = 1'b1;
            busy_d       = 1'b0;
            tick_cnt_d   = '0;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      par_en_q     <= 1'b0;
      shift_q      <= '0;
      start_smp_q  <= 1'b0;
      par_smp_q    <= 1'b1;
      raw_data_q   <= '0;
      parity_bit_q <= 1'b1;
      start_bit_q  <= 1'b0;
      stop_bit_q   <= 1'b1;
      flag_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= rx_serial;
      rx_s_q       <= sync1_q;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      par_en_q     <= par_en_d;
      shift_q      <= shift_d;
      start_smp_q  <= start_smp_d;
      par_smp_q    <= par_smp_d;
      raw_data_q   <= raw_data_d;
      parity_bit_q <= parity_bit_d;
      start_bit_q  <= start_bit_d;
      stop_bit_q   <= stop_bit_d;
      flag_q       <= flag_d;
      busy_q       <= busy_d;
    end
  end

  assign raw_data      = raw_data_q;
  assign parity_bit    = parity_bit_q;
  assign start_bit     = start_bit_q;
  assign stop_bit      = stop_bit_q;
  assign recieved_flag = flag_q;
  assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_deframe.sv
// Scoreboard bench for uart_rx_deframe: frames are queued as they are driven and
// checked (fields and tick timing) when recieved_flag rises.
module tb_uart_rx_deframe;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       baud_tick16;
  logic       rx_serial;
  logic [1:0] parity_type;
  logic [7:0] raw_data;
  logic       parity_bit, start_bit, stop_bit, recieved_flag, rx_busy;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       start;
    logic       stop;
    int         ticks;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_errors = 0;
  int         tb_ticks = 0;
  int         tick_div = 0;
  logic [7:0] last_data = 8'h00;
  bit         have_last = 1'b0;
  logic       flag_prev = 1'b0;

  uart_rx_deframe dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .baud_tick16  (baud_tick16),
    .rx_serial    (rx_serial),
    .parity_type  (parity_type),
    .raw_data     (raw_data),
    .parity_bit   (parity_bit),
    .start_bit    (start_bit),
    .stop_bit     (stop_bit),
    .recieved_flag(recieved_flag),
    .rx_busy      (rx_busy)
  );

  always #5 clock = ~clock;

  // One-clock tick every 4 clocks.
  initial begin
    baud_tick16 = 1'b0;
    forever begin
      @(negedge clock);
      baud_tick16 = (tick_div == 3);
      tick_div    = (tick_div + 1) % 4;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clock); while (baud_tick16 !== 1'b1);
    end
  endtask

  // Drives a frame; the start edge lands just after a tick, so the DUT detects
  // on the next tick and the stop mid-sample is the 153rd (169th) tick after the edge.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] pt_mid,
                            input logic par_val, input logic stop_val);
    exp_t e;
    bit   has_par;
    has_par     = (pt == 2'b01) || (pt == 2'b10);
    parity_type = pt;
    e.data  = d;
    e.par   = has_par ? par_val : 1'b1;
    e.start = 1'b0;
    e.stop  = stop_val;
    e.ticks = has_par ? 169 : 153;
    sb_q.push_back(e);
    @(negedge clock);
    rx_serial = 1'b0;
    tb_ticks  = 0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      rx_serial = d[i];
      if (i == 0) parity_type = pt_mid;
      wait_ticks(16);
    end
    if (has_par) begin
      @(negedge clock);
      rx_serial = par_val;
      wait_ticks(16);
    end
    @(negedge clock);
    rx_serial = stop_val;
    if (stop_val) wait_ticks(16);
    else begin
      wait_ticks(9);
      @(negedge clock);
      rx_serial = 1'b1;
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (baud_tick16) tb_ticks++;
    if (reset_n) begin
      if (recieved_flag && !flag_prev) begin
        if (sb_q.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
        else begin
          mon_e = sb_q.pop_front();
          check("raw_data",   raw_data,    mon_e.data);
          check("parity_bit", parity_bit,  mon_e.par);
          check("start_bit",  start_bit,   mon_e.start);
          check("stop_bit",   stop_bit,    mon_e.stop);
          check("busy_done",  rx_busy,     1'b0);
          check("flag_tick",  tb_ticks,    mon_e.ticks);
          check("flag_edge",  baud_tick16, 1'b1);
          last_data = mon_e.data;
          have_last = 1'b1;
        end
      end
      if (!recieved_flag && flag_prev) begin
        check("busy_at_detect", rx_busy, 1'b1);
        if (have_last) check("raw_hold", raw_data, last_data);
      end
    end
    flag_prev = recieved_flag;
  end

  initial begin
    reset_n     = 1'b0;
    rx_serial   = 1'b1;
    parity_type = 2'b00;
    #12;
    check("rst_raw",    raw_data,      8'h00);
    check("rst_par",    parity_bit,    1'b1);
    check("rst_start",  start_bit,     1'b0);
    check("rst_stop",   stop_bit,      1'b1);
    check("rst_flag",   recieved_flag, 1'b0);
    check("rst_busy",   rx_busy,       1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    wait_ticks(5);
    send_frame(8'hA5, 2'b00, 2'b00, 1'b1, 1'b1);
    wait_ticks(10);
    send_frame(8'h3C, 2'b10, 2'b10, 1'b0, 1'b1);
    wait_ticks(10);
    send_frame(8'h01, 2'b01, 2'b01, 1'b0, 1'b1);
    wait_ticks(10);

    // Framing error: the FSM must be back in IDLE with the flag held.
    send_frame(8'hFF, 2'b00, 2'b00, 1'b1, 1'b0);
    wait_ticks(30);
    check("ferr_idle_busy", rx_busy,       1'b0);
    check("ferr_idle_flag", recieved_flag, 1'b1);
    check("ferr_stop",      stop_bit,      1'b0);

    // Back-to-back: second start edge right at the end of the first stop bit.
    wait_ticks(10);
    send_frame(8'h12, 2'b00, 2'b00, 1'b1, 1'b1);
    send_frame(8'h34, 2'b00, 2'b00, 1'b1, 1'b1);
    wait_ticks(10);

    // Reset during data bit 4 of 0x55.
    parity_type = 2'b00;
    @(negedge clock);
    rx_serial = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      rx_serial = i[0] ? 1'b0 : 1'b1;
      wait_ticks(i == 4 ? 4 : 16);
    end
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_busy",  rx_busy,       1'b0);
    check("mrst_raw",   raw_data,      8'h00);
    check("mrst_par",   parity_bit,    1'b1);
    check("mrst_start", start_bit,     1'b0);
    check("mrst_stop",  stop_bit,      1'b1);
    check("mrst_flag",  recieved_flag, 1'b0);
    rx_serial = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    wait_ticks(5);
    send_frame(8'hC3, 2'b00, 2'b00, 1'b1, 1'b1);
    wait_ticks(10);

    // parity_type drops to 00 mid-frame; parity must still be sampled.
    send_frame(8'h96, 2'b10, 2'b00, 1'b0, 1'b1);
    wait_ticks(10);

    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(posedge clock);
    check("sb_drain", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframe.md
Name: uart_rx_deframe

Overview:
- Receive-side front end of the UART-Rx path. Oversamples the asynchronous serial line at 16x and detects the start edge.
- Mid-bit samples start, 8 data bits (LSB first), an optional parity bit and the stop bit. Assembles them serially into a register and holds the frame fields stable for ErrorCheck.
- Sits directly upstream of ErrorCheck: drives its raw_data, parity_bit, start_bit, stop_bit and recieved_flag inputs.

Parameters:
- OVERSAMPLE, 16, baud_tick16 pulses per bit period. Must be even, at least 8.
- MID_SAMPLE, 7, tick_cnt value at which a bit is sampled (OVERSAMPLE/2 - 1).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- baud_tick16  input  1  one-clock enable pulse at OVERSAMPLE x baud rate.
- rx_serial  input  1  asynchronous serial line, idle high.
- parity_type  input  2  01 = ODD, 10 = EVEN, 00/11 = no parity.
- raw_data  output  8  received data byte.
- parity_bit  output  1  received parity bit; forced 1 when no parity.
- start_bit  output  1  start-bit sample.
- stop_bit  output  1  stop-bit sample.
- recieved_flag  output  1  frame-complete level; fields valid while high.
- rx_busy  output  1  high while a frame is being received.

Behaviour:
- Reset (async, reset_n=0): raw_data=8'h00, parity_bit=1, start_bit=0, stop_bit=1, recieved_flag=0, rx_busy=0, FSM=IDLE, tick_cnt=0, bit_cnt=0, synchronizer flops=1. All take effect immediately, mid-frame included. Release resumes in IDLE.
- Synchronizer: rx_serial passes through 2 flops (rx_s). All FSM decisions use rx_s only.
- tick_cnt (4 bits for default): advances only on baud_tick16. Wraps OVERSAMPLE-1 -> 0. No activity between ticks.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a tick with rx_s==0:
  - go to START; tick_cnt=0.
  - latch parity_type into par_en. Mid-frame parity_type changes are ignored.
  - clear recieved_flag; set rx_busy=1.
  - rx_s==1 -> stay in IDLE.
- START: on a tick with tick_cnt==MID_SAMPLE, capture start_bit=rx_s. No abort on a high sample; downstream flags it. On a tick with tick_cnt==OVERSAMPLE-1, go to DATA with bit_cnt=0.
- DATA: on the mid tick, shift rx_s into shift_reg at MSB; after 8 bits the LSB-first byte is aligned. On the last tick:
  - bit_cnt<7 -> increment.
  - bit_cnt==7 -> go to PARITY if par_en is ODD/EVEN, else STOP.
- PARITY: on the mid tick, capture parity_bit=rx_s. On the last tick, go to STOP.
- STOP: on the mid tick:
  - capture stop_bit=rx_s; raw_data=shift_reg.
  - if no parity, parity_bit=1.
  - recieved_flag=1, rx_busy=0; go to IDLE.
  - The frame completes at mid-stop to allow back-to-back frames.
- Timing, with the detection tick = tick 0:
  - data bit i sampled on tick 16*(i+1)+8.
  - stop sampled on tick 152 (no parity) or 168 (parity).
  - recieved_flag and the fields are registered and visible the clock after that tick.
- Hold: raw_data, parity_bit, start_bit and stop_bit change only on the mid-stop update. They stay stable through the next frame's reception.
- recieved_flag: high from completion until the next start detection in IDLE; it is a level, not a pulse.
- A stop sample of 0 does not stall; frame completes with stop_bit=0. A continuously low line re-detects start on the next tick in IDLE.
- baud_tick16 on the same clock as a state update: counters use the pre-update state; no skipped or doubled ticks.

Test Plan:
- No parity (00), send 0xA5 with start=0 and stop=1 -> first tick of detection 0:
  - recieved_flag rises one clock after tick 152.
  - raw_data=8'hA5, parity_bit=1, start_bit=0, stop_bit=1, rx_busy falls with the flag.
- EVEN (10), send 0x3C with parity bit 0 -> flag rises after tick 168; raw_data=8'h3C, parity_bit=0.
  - Repeat with ODD (01), 0x01, parity 0 -> parity_bit=0, raw_data=8'h01.
- Framing error, stop bit driven 0 with data 0xFF, no parity -> stop_bit=0, raw_data=8'hFF, recieved_flag=1, FSM back in IDLE.
- Back-to-back frames 0x12 then 0x34, the second start edge at the end of the first stop bit:
  - flag drops at the second start detection.
  - flag rises again with raw_data=8'h34.
  - raw_data holds 0x12 in between.
- Reset mid-frame, assert reset_n=0 during DATA bit 4 of 0x55:
  - all outputs at reset values immediately.
  - after release, a full frame 0xC3 receives correctly.
- parity_type changed from 10 to 00 during DATA of an EVEN frame -> parity still sampled; flag after tick 168.
